// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: bit-serial Montgomery modular exponentiation, C = M^E mod P.
// Left-to-right square-and-multiply over E. Each Montgomery product takes
// W+2 cycles: one LOAD, W radix-2 iterations, one final correction.
// Optional build macro RSA_MODEXP_ERRCHK_EN enables operand validation
// (p even, p < 3, m >= p) on the start edge. Without it, err is tied to 0.
module rsa_modexp_engine #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] p,
    input  logic [W-1:0] e,
    input  logic [W-1:0] m,
    input  logic [W-1:0] r2,
    output logic         busy,
    output logic         eoc,
    output logic [W-1:0] c,
    output logic         err
);

    localparam int CW = $clog2(W + 2);
    localparam int JW = $clog2(W);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE_M, S_PRE_X, S_SQR, S_MUL, S_POST, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [JW-1:0]   j_q, j_d;
    logic [W-1:0]    p_q, p_d, e_q, e_d, m_q, m_d, r2_q, r2_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W+1:0]    s_q, s_d;
    logic [W-1:0]    mbar_q, mbar_d, x_q, x_d;
    logic            busy_q, busy_d, eoc_q, eoc_d, err_q, err_d;
    logic [W-1:0]    c_q, c_d;

    logic [W-1:0]    op_a_s, op_b_s, mm_res_s;
    logic [W+1:0]    s_add_s, s_odd_s, s_corr_s;
    logic            bad_s;

`ifdef RSA_MODEXP_ERRCHK_EN
    assign bad_s = ~p[0] | (p < W'(3)) | (m >= p);
`else
    assign bad_s = 1'b0;
`endif

    // One radix-2 Montgomery step, plus the final conditional subtraction.
    assign s_add_s  = s_q + (a_q[0] ? {2'b00, b_q} : {(W+2){1'b0}});
    assign s_odd_s  = s_add_s + (s_add_s[0] ? {2'b00, p_q} : {(W+2){1'b0}});
    assign s_corr_s = (s_q >= {2'b00, p_q}) ? (s_q - {2'b00, p_q}) : s_q;
    assign mm_res_s = s_corr_s[W-1:0];

    // Operand selection for the product that the current state performs.
    always_comb begin
        op_a_s = {W{1'b0}};
        op_b_s = {W{1'b0}};
        case (state_q)
            S_PRE_M: begin op_a_s = m_q;    op_b_s = r2_q; end
            S_PRE_X: begin op_a_s = W'(1);  op_b_s = r2_q; end
            S_SQR:   begin op_a_s = x_q;    op_b_s = x_q;  end
            S_MUL:   begin op_a_s = mbar_q; op_b_s = x_q;  end
            S_POST:  begin op_a_s = x_q;    op_b_s = W'(1); end
            default: begin op_a_s = {W{1'b0}}; op_b_s = {W{1'b0}}; end
        endcase
    end

    // Next-state, datapath and output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        p_d     = p_q;
        e_d     = e_q;
        m_d     = m_q;
        r2_d    = r2_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        mbar_d  = mbar_q;
        x_d     = x_q;
        busy_d  = busy_q;
        eoc_d   = 1'b0;
        err_d   = err_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p_d  = p;
                    e_d  = e;
                    m_d  = m;
                    r2_d = r2;
                    if (bad_s) begin
                        state_d = S_DONE;
                        eoc_d   = 1'b1;
                        err_d   = 1'b1;
                        c_d     = {W{1'b0}};
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_PRE_M;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        cnt_d   = {CW{1'b0}};
                        j_d     = JW'(W - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE_M, S_PRE_X, S_SQR, S_MUL, S_POST: begin
                if (cnt_q == {CW{1'b0}}) begin
                    a_d   = op_a_s;
                    b_d   = op_b_s;
                    s_d   = {(W+2){1'b0}};
                    cnt_d = CW'(1);
                end else if (cnt_q <= CW'(W)) begin
                    s_d   = s_odd_s >> 1;
                    a_d   = a_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = {CW{1'b0}};
                    case (state_q)
                        S_PRE_M: begin
                            mbar_d  = mm_res_s;
                            state_d = S_PRE_X;
                        end
                        S_PRE_X: begin
                            x_d     = mm_res_s;
                            state_d = S_SQR;
                        end
                        S_SQR: begin
                            x_d = mm_res_s;
                            if (e_q[j_q]) begin
                                state_d = S_MUL;
                            end else if (j_q == {JW{1'b0}}) begin
                                state_d = S_POST;
                            end else begin
                                j_d     = j_q - JW'(1);
                                state_d = S_SQR;
                            end
                        end
                        S_MUL: begin
                            x_d = mm_res_s;
                            if (j_q == {JW{1'b0}}) begin
                                state_d = S_POST;
                            end else begin
                                j_d     = j_q - JW'(1);
                                state_d = S_SQR;
                            end
                        end
                        S_POST: begin
                            c_d     = mm_res_s;
                            eoc_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_DONE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            j_q     <= {JW{1'b0}};
            p_q     <= {W{1'b0}};
            e_q     <= {W{1'b0}};
            m_q     <= {W{1'b0}};
            r2_q    <= {W{1'b0}};
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            s_q     <= {(W+2){1'b0}};
            mbar_q  <= {W{1'b0}};
            x_q     <= {W{1'b0}};
            busy_q  <= 1'b0;
            eoc_q   <= 1'b0;
            err_q   <= 1'b0;
            c_q     <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            p_q     <= p_d;
            e_q     <= e_d;
            m_q     <= m_d;
            r2_q    <= r2_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            mbar_q  <= mbar_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            eoc_q   <= eoc_d;
            err_q   <= err_d;
            c_q     <= c_d;
        end
    end

    assign busy = busy_q;
    assign eoc  = eoc_q;
    assign c    = c_q;
    assign err  = err_q;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Testbench for rsa_modexp_engine (W=8). Expected results come from a
// repeated-multiplication reference model and are queued at start time.
module tb_rsa_modexp_engine;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] p = '0, e = '0, m = '0, r2 = '0;
    logic         busy, eoc, err;
    logic [W-1:0] c;

    typedef struct {
        logic [W-1:0] c;
        logic         err;
        int           busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   busy_acc = 0;
    int   eoc_cnt = 0;

    rsa_modexp_engine #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .p(p), .e(e), .m(m),
        .r2(r2), .busy(busy), .eoc(eoc), .c(c), .err(err)
    );

    always #5 clk = ~clk;

    // Count busy cycles and eoc cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_acc <= busy_acc + 1;
        if (eoc === 1'b1) eoc_cnt <= eoc_cnt + 1;
    end

    function automatic logic [W-1:0] ref_pow(input int pp, input int ee, input int mm);
        longint r;
        r = 1;
        for (int i = 0; i < ee; i++) r = (r * mm) % pp;
        return W'(r);
    endfunction

    // Drive one start pulse and queue the expected outcome.
    task automatic issue(input int pp, input int ee, input int mm);
        exp_t x;
        bit   inv;
        inv = 1'b0;
`ifdef RSA_MODEXP_ERRCHK_EN
        inv = (pp % 2 == 0) || (pp < 3) || (mm >= pp);
`endif
        if (inv) begin
            x.c = '0; x.err = 1'b1; x.busy = 0;
        end else begin
            x.c = ref_pow(pp, ee, mm); x.err = 1'b0;
            x.busy = (W + 3 + $countones(ee)) * (W + 2);
        end
        sb.push_back(x);
        @(posedge clk); #1;
        busy_acc = 0;
        eoc_cnt  = 0;
        p  = W'(pp);
        e  = W'(ee);
        m  = W'(mm);
        r2 = (pp > 0) ? W'((1 << (2 * W)) % pp) : '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_eoc(input int limit);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit; n++) begin
            if (eoc === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL eoc_timeout: eoc not seen within %0d cycles", limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (eoc !== 1'b0) begin failures++; $display("FAIL reset_eoc: got %b want 0", eoc); end
        if (c !== '0) begin failures++; $display("FAIL reset_c: got %0d want 0", c); end
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_modexp();
        int tp[5], te[5], tm[5];
        exp_t x;
        tp[0] = 187; te[0] = 7; tm[0] = 88;
        for (int k = 1; k < 5; k++) begin
            tp[k] = ($urandom_range(1, 127) * 2) + 1;
            tm[k] = $urandom_range(0, tp[k] - 1);
            te[k] = $urandom_range(0, 255);
        end
        for (int k = 0; k < 5; k++) begin
            issue(tp[k], te[k], tm[k]);
            wait_eoc(400);
            x = sb.pop_front();
            checks += 3;
            if (c !== x.c) begin failures++; $display("FAIL modexp_c: p=%0d e=%0d m=%0d got %0d want %0d", tp[k], te[k], tm[k], c, x.c); end
            if (err !== x.err) begin failures++; $display("FAIL modexp_err: got %b want %b", err, x.err); end
            if (busy_acc != x.busy) begin failures++; $display("FAIL modexp_busy: got %0d want %0d", busy_acc, x.busy); end
            @(posedge clk); #1;
            checks++;
            if (eoc !== 1'b0) begin failures++; $display("FAIL eoc_width: eoc still %b", eoc); end
        end
    endtask

    task automatic test_identity_zero();
        int te[4], tm[4];
        exp_t x;
        te[0] = 1; tm[0] = 100;
        te[1] = 0; tm[1] = 100;
        te[2] = 5; tm[2] = 0;
        te[3] = 0; tm[3] = 0;
        for (int k = 0; k < 4; k++) begin
            issue(187, te[k], tm[k]);
            wait_eoc(400);
            x = sb.pop_front();
            checks += 2;
            if (c !== x.c) begin failures++; $display("FAIL ident_c: e=%0d m=%0d got %0d want %0d", te[k], tm[k], c, x.c); end
            if (busy_acc != x.busy) begin failures++; $display("FAIL ident_busy: e=%0d got %0d want %0d", te[k], busy_acc, x.busy); end
        end
    endtask

    task automatic test_start_during_busy();
        exp_t x;
        issue(187, 7, 88);
        repeat (19) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_eoc(400);
        x = sb.pop_front();
        checks++;
        if (c !== x.c) begin failures++; $display("FAIL busy_start_c: got %0d want %0d", c, x.c); end
        repeat (200) begin @(posedge clk); end
        #1;
        checks += 2;
        if (eoc_cnt != 1) begin failures++; $display("FAIL busy_start_eocs: got %0d want 1", eoc_cnt); end
        if (busy_acc != x.busy) begin failures++; $display("FAIL busy_start_ext: got %0d want %0d", busy_acc, x.busy); end
        issue(187, 3, 2);
        wait_eoc(400);
        x = sb.pop_front();
        checks++;
        if (c !== x.c) begin failures++; $display("FAIL busy_start_next: got %0d want %0d", c, x.c); end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        issue(187, 2, 5);
        wait_eoc(400);
        x = sb.pop_front();
        checks++;
        if (c !== x.c) begin failures++; $display("FAIL b2b_c: got %0d want %0d", c, x.c); end
        busy_acc = 0;
        start = 1'b1;
        e = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); end
        #1;
        checks++;
        if (busy_acc != 0) begin failures++; $display("FAIL b2b_ignored: busy cycles %0d want 0", busy_acc); end
        issue(187, 7, 88);
        wait_eoc(400);
        x = sb.pop_front();
        checks++;
        if (c !== x.c) begin failures++; $display("FAIL b2b_next: got %0d want %0d", c, x.c); end
    endtask

    task automatic test_operand_stability();
        exp_t x;
        issue(187, 7, 88);
        p = 8'd85; e = 8'd255; m = 8'd3; r2 = 8'd1;
        wait_eoc(400);
        x = sb.pop_front();
        checks++;
        if (c !== x.c) begin failures++; $display("FAIL stable_c: got %0d want %0d", c, x.c); end
        issue(187, 3, 2);
        repeat (30) begin @(posedge clk); end
        #1;
        checks++;
        if (c !== 8'd11) begin failures++; $display("FAIL stable_hold: got %0d want 11", c); end
        wait_eoc(400);
        x = sb.pop_front();
        checks++;
        if (c !== x.c) begin failures++; $display("FAIL stable_next: got %0d want %0d", c, x.c); end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        issue(187, 7, 88);
        repeat (48) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (c !== '0) begin failures++; $display("FAIL rstmid_c: got %0d want 0", c); end
        if (eoc !== 1'b0) begin failures++; $display("FAIL rstmid_eoc: got %b want 0", eoc); end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        eoc_cnt = 0;
        repeat (200) begin @(posedge clk); end
        #1;
        checks++;
        if (eoc_cnt != 0) begin failures++; $display("FAIL rstmid_noeoc: got %0d eoc cycles want 0", eoc_cnt); end
        issue(187, 7, 88);
        wait_eoc(400);
        x = sb.pop_front();
        checks++;
        if (c !== x.c) begin failures++; $display("FAIL rstmid_rerun: got %0d want %0d", c, x.c); end
    endtask

`ifdef RSA_MODEXP_ERRCHK_EN
    task automatic test_errchk();
        int tp[4], tm[4];
        exp_t x;
        tp[0] = 186; tm[0] = 88;
        tp[1] = 187; tm[1] = 200;
        tp[2] = 1;   tm[2] = 0;
        tp[3] = 187; tm[3] = 88;
        for (int k = 0; k < 4; k++) begin
            issue(tp[k], 7, tm[k]);
            wait_eoc(400);
            x = sb.pop_front();
            checks += 3;
            if (c !== x.c) begin failures++; $display("FAIL errchk_c: p=%0d m=%0d got %0d want %0d", tp[k], tm[k], c, x.c); end
            if (err !== x.err) begin failures++; $display("FAIL errchk_err: p=%0d m=%0d got %b want %b", tp[k], tm[k], err, x.err); end
            if (busy_acc != x.busy) begin failures++; $display("FAIL errchk_busy: got %0d want %0d", busy_acc, x.busy); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_modexp();
        test_identity_zero();
        test_start_during_busy();
        test_back_to_back();
        test_operand_stability();
        test_reset_mid();
`ifdef RSA_MODEXP_ERRCHK_EN
        test_errchk();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
